param_multi_mode_counter: RTL and testbench
===========================================

Name: param_multi_mode_counter

Overview:
- Parametrised next generation of the multi-mode game counter.
- Counts up or down by one of two parameter-set step sizes and scores a winner event on reaching all-ones and a loser event on reaching zero.
- Keeps saturating win and loss tallies and declares gameover when either tally hits a parameter-set limit.
- New versus the previous generation: parameter-set width, steps and limit; a count enable; exposed tallies; and a restart that clears gameover without a full reset.

Parameters:
- WIDTH, 5, counter width in bits; must be at least 2.
- STEP_SMALL, 1, step used in modes 00 and 10; must satisfy 1 <= STEP_SMALL < 2^WIDTH.
- STEP_LARGE, 2, step used in modes 01 and 11; must satisfy 1 <= STEP_LARGE < 2^WIDTH.
- GAME_LIMIT, 15, tally value that triggers gameover; must be at least 1.
- TALLY_W, $clog2(GAME_LIMIT+1), tally width in bits (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 up by STEP_SMALL; 01 up by STEP_LARGE; 10 down by STEP_SMALL; 11 down by STEP_LARGE.
- en  in  1  count enable.
- init  in  1  synchronous load request.
- init_val  in  WIDTH  value loaded when init is honoured.
- restart  in  1  synchronous game clear.
- count  out  WIDTH  current count.
- winner  out  1  one-cycle pulse: the count was just updated to 2^WIDTH-1.
- loser  out  1  one-cycle pulse: the count was just updated to 0.
- who  out  2  00 none; 01 winner tally caused gameover; 10 loser tally caused gameover.
- gameover  out  1  sticky end-of-game flag.
- win_tally  out  TALLY_W  number of winner events, saturating at GAME_LIMIT.
- lose_tally  out  TALLY_W  number of loser events, saturating at GAME_LIMIT.

Behaviour:
- Reset: when rst is asserted, all outputs go to 0 immediately, without waiting for a clock edge. This covers count, winner, loser, who, gameover and both tallies. Release of rst takes effect at the next edge. Reset is never scored.
- Priority at each edge, highest first:
  1. restart
  2. gameover freeze
  3. init
  4. en counting
  5. hold
- restart: count, tallies, who and gameover all go to 0. No winner or loser pulse is produced.
- Freeze: while gameover=1, count and tallies hold, and init and en are ignored. winner and loser are 0.
- init: count <= init_val. The load is an update and is scored.
- Counting (en=1): count <= count ± step, computed modulo 2^WIDTH. Mode is sampled at each edge, so mode changes mid-run are legal and take effect at the next edge.
- Hold (en=0 and init=0): count holds. winner and loser are 0, because only updates are scored.
- Scoring: winner and loser are registered and asserted in the same cycle as the new count value. They are high for exactly one cycle per update.
  - Two consecutive updates landing on the same value give two consecutive pulses, and each is tallied.
  - Wrap cases score normally. Up-wrap 30+2 → 0 is a loser event. Down-wrap 1-2 → 31 is a winner event.
- Tallies: each winner or loser event increments its tally. Tallies saturate at GAME_LIMIT.
- Gameover: on the edge where a tally reaches GAME_LIMIT, gameover goes to 1 and who is set to 01 (win tally) or 10 (loss tally).
  - The final pulse is still emitted in that same cycle.
  - Both tallies cannot reach the limit on the same edge, since 0 ≠ 2^WIDTH-1.
- rst asserted mid-operation overrides everything, including gameover.

Test Plan (defaults: WIDTH=5, steps 1/2, GAME_LIMIT=15):
1. Async reset: mode=00, en=1, count at 7; pulse rst for 3 ns between edges → count=0 and tallies=0 before the next edge. After release, the first edge gives count=1.
2. Mode 00 from reset with en=1:
   - Edge 31: count=31 with a single-cycle winner pulse.
   - Edge 32: count=0 with a loser pulse.
   - After the 15th winner: gameover=1, who=01, count frozen at 31, win_tally=15, lose_tally=14.
3. Mode 11 after init to 31, with win_tally=0 and lose_tally=0 at the load:
   - The load itself is a winner event: win_tally=1.
   - Sequence 29, 27, … 1, 31; the 1→31 wrap is winner event 2.
   - loser is never asserted.
   - Gameover with who=01 falls on the 15th winner event, including the one from the initial load.
4. init priority: mode=01, en=1, init=1, init_val=0 → count=0, loser pulse, lose_tally increments by exactly 1; the step is not applied that edge.
5. During gameover:
   - init=1 and en=1: no change.
   - restart=1 for one edge: count=0, tallies=0, gameover=0, who=00, no pulse.
   - Counting resumes on the next edge.
6. en=0 with count held at 31 for 5 cycles → winner=0 throughout and win_tally unchanged. A mode change from 00 to 10 while en=0 has no effect until en returns to 1.

Source files
------------

// File: rtl/param_multi_mode_counter.sv
// Parametrised up/down game counter: scores all-ones/zero updates into saturating
// win/loss tallies and freezes on gameover until restart or reset.
module param_multi_mode_counter #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned STEP_SMALL = 1,
  parameter int unsigned STEP_LARGE = 2,
  parameter int unsigned GAME_LIMIT = 15,
  parameter int unsigned TALLY_W    = $clog2(GAME_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               en,
  input  logic               init,
  input  logic [WIDTH-1:0]   init_val,
  input  logic               restart,
  output logic [WIDTH-1:0]   count,
  output logic               winner,
  output logic               loser,
  output logic [1:0]         who,
  output logic               gameover,
  output logic [TALLY_W-1:0] win_tally,
  output logic [TALLY_W-1:0] lose_tally
);

  localparam logic [WIDTH-1:0]   StepSmall = WIDTH'(STEP_SMALL);
  localparam logic [WIDTH-1:0]   StepLarge = WIDTH'(STEP_LARGE);
  localparam logic [TALLY_W-1:0] Limit     = TALLY_W'(GAME_LIMIT);
  localparam logic [1:0]         WhoNone   = 2'b00;
  localparam logic [1:0]         WhoWin    = 2'b01;
  localparam logic [1:0]         WhoLose   = 2'b10;

  logic [WIDTH-1:0]   count_q, count_d, next_count, step;
  logic               winner_q, winner_d, loser_q, loser_d;
  logic [1:0]         who_q, who_d;
  logic               gameover_q, gameover_d;
  logic [TALLY_W-1:0] win_tally_q, win_tally_d, lose_tally_q, lose_tally_d;
  logic               update;

  always_comb begin
    count_d      = count_q;
    winner_d     = 1'b0;
    loser_d      = 1'b0;
    who_d        = who_q;
    gameover_d   = gameover_q;
    win_tally_d  = win_tally_q;
    lose_tally_d = lose_tally_q;
    update       = 1'b0;
    step         = mode[0] ? StepLarge : StepSmall;
    next_count   = count_q;

    if (restart) begin
      count_d      = '0;
      who_d        = WhoNone;
      gameover_d   = 1'b0;
      win_tally_d  = '0;
      lose_tally_d = '0;
    end else if (!gameover_q) begin
      if (init) begin
        next_count = init_val;
        update     = 1'b1;
      end else if (en) begin
        // Modulo 2^WIDTH wrap falls out of the fixed-width add/subtract.
        next_count = mode[1] ? (count_q - step) : (count_q + step);
        update     = 1'b1;
      end

      if (update) begin
        count_d  = next_count;
        winner_d = (next_count == {WIDTH{1'b1}});
        loser_d  = (next_count == '0);
        if (winner_d && (win_tally_q != Limit)) begin
          win_tally_d = win_tally_q + TALLY_W'(1);
          if (win_tally_d == Limit) begin
            gameover_d = 1'b1;
            who_d      = WhoWin;
          end
        end
        if (loser_d && (lose_tally_q != Limit)) begin
          lose_tally_d = lose_tally_q + TALLY_W'(1);
          if (lose_tally_d == Limit) begin
            gameover_d = 1'b1;
            who_d      = WhoLose;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      winner_q     <= 1'b0;
      loser_q      <= 1'b0;
      who_q        <= WhoNone;
      gameover_q   <= 1'b0;
      win_tally_q  <= '0;
      lose_tally_q <= '0;
    end else begin
      count_q      <= count_d;
      winner_q     <= winner_d;
      loser_q      <= loser_d;
      who_q        <= who_d;
      gameover_q   <= gameover_d;
      win_tally_q  <= win_tally_d;
      lose_tally_q <= lose_tally_d;
    end
  end

  assign count      = count_q;
  assign winner     = winner_q;
  assign loser      = loser_q;
  assign who        = who_q;
  assign gameover   = gameover_q;
  assign win_tally  = win_tally_q;
  assign lose_tally = lose_tally_q;

endmodule

// File: tb/tb_param_multi_mode_counter.sv
// Scoreboard bench for param_multi_mode_counter at default parameters
// (WIDTH=5, steps 1/2, GAME_LIMIT=15).
module tb_param_multi_mode_counter;

  typedef struct packed {
    logic [4:0] cnt;
    logic       win;
    logic       lose;
    logic [1:0] who;
    logic       go;
    logic [3:0] wt;
    logic [3:0] lt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       en = 1'b0;
  logic       init = 1'b0;
  logic [4:0] init_val = '0;
  logic       restart = 1'b0;
  logic [4:0] count;
  logic       winner, loser, gameover;
  logic [1:0] who;
  logic [3:0] win_tally, lose_tally;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state (plain integers, modulo arithmetic done explicitly).
  int m_cnt = 0, m_wt = 0, m_lt = 0, m_who = 0;
  bit m_go = 1'b0;
  obs_t sb[$];

  param_multi_mode_counter dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .en         (en),
    .init       (init),
    .init_val   (init_val),
    .restart    (restart),
    .count      (count),
    .winner     (winner),
    .loser      (loser),
    .who        (who),
    .gameover   (gameover),
    .win_tally  (win_tally),
    .lose_tally (lose_tally)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {count, winner, loser, who, gameover, win_tally, lose_tally};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("cnt=%0d win=%b lose=%b who=%b go=%b wt=%0d lt=%0d",
                     o.cnt, o.win, o.lose, o.who, o.go, o.wt, o.lt);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wt = 0; m_lt = 0; m_who = 0; m_go = 1'b0;
    sb.delete();
  endtask

  // Drive one edge's inputs, push the model's prediction, then advance to edge+1.
  task automatic drive(input logic r, input logic i, input logic e, input logic [1:0] md,
                       input logic [4:0] iv);
    obs_t x;
    bit   w = 1'b0, l = 1'b0, upd = 1'b0;
    int   nc = m_cnt;
    restart = r; init = i; en = e; mode = md; init_val = iv;
    if (r) begin
      m_cnt = 0; m_wt = 0; m_lt = 0; m_who = 0; m_go = 1'b0;
    end else if (!m_go) begin
      if (i) begin
        nc = int'(iv); upd = 1'b1;
      end else if (e) begin
        nc = md[1] ? (m_cnt + 32 - (md[0] ? 2 : 1)) % 32 : (m_cnt + (md[0] ? 2 : 1)) % 32;
        upd = 1'b1;
      end
      if (upd) begin
        m_cnt = nc;
        w = (nc == 31);
        l = (nc == 0);
        if (w && m_wt < 15) begin
          m_wt++;
          if (m_wt == 15) begin m_go = 1'b1; m_who = 1; end
        end
        if (l && m_lt < 15) begin
          m_lt++;
          if (m_lt == 15) begin m_go = 1'b1; m_who = 2; end
        end
      end
    end
    x.cnt = 5'(m_cnt); x.win = w; x.lose = l; x.who = 2'(m_who);
    x.go = m_go; x.wt = 4'(m_wt); x.lt = 4'(m_lt);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    #1;
    got = sample();
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset_init got %s expected all zero", fmt(got));
    end
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL reset_count edge %0d got %s expected %s", k, fmt(got), fmt(e));
      end
    end
    #1 rst = 1'b1;
    #2;
    got = sample();
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++; $display("FAIL async_reset got %s expected all zero", fmt(got));
    end
    #1 rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got !== e || got.cnt !== 5'd1) begin
      n_fail++; $display("FAIL reset_release got %s expected %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_mode00();
    obs_t got, e;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 479; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL mode00 edge %0d got %s expected %s", k, fmt(got), fmt(e));
      end
      if (k == 31) begin
        n_checks++;
        if (got.cnt !== 5'd31 || got.win !== 1'b1 || got.lose !== 1'b0) begin
          n_fail++; $display("FAIL mode00_first_win got %s expected cnt=31 win=1", fmt(got));
        end
      end
      if (k == 32) begin
        n_checks++;
        if (got.cnt !== 5'd0 || got.win !== 1'b0 || got.lose !== 1'b1) begin
          n_fail++; $display("FAIL mode00_first_lose got %s expected cnt=0 lose=1", fmt(got));
        end
      end
    end
    got = sample();
    n_checks++;
    if (got !== {5'd31, 1'b1, 1'b0, 2'b01, 1'b1, 4'd15, 4'd14}) begin
      n_fail++;
      $display("FAIL mode00_gameover got %s expected cnt=31 win=1 who=01 go=1 wt=15 lt=14",
               fmt(got));
    end
  endtask

  task automatic test_gameover_restart();
    obs_t got, e;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 2'(k), 5'd5);
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e || got.cnt !== 5'd31 || got.go !== 1'b1) begin
        n_fail++; $display("FAIL freeze edge %0d got %s expected %s", k, fmt(got), fmt(e));
      end
    end
    drive(1'b1, 1'b1, 1'b1, 2'b00, 5'd5);
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got !== e || got !== obs_t'(0)) begin
      n_fail++; $display("FAIL restart got %s expected %s", fmt(got), fmt(e));
    end
    drive(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got !== e || got.cnt !== 5'd1) begin
      n_fail++; $display("FAIL resume got %s expected %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_mode11();
    obs_t got, e;
    bit   saw_lose = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b11, 5'd0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b1, 2'b11, 5'd31);
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got !== e || got.wt !== 4'd1 || got.win !== 1'b1) begin
      n_fail++; $display("FAIL mode11_load got %s expected %s", fmt(got), fmt(e));
    end
    for (int k = 1; k <= 224; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b11, 5'd0);
      got = sample(); e = sb.pop_front();
      if (got.lose) saw_lose = 1'b1;
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL mode11 edge %0d got %s expected %s", k, fmt(got), fmt(e));
      end
      if (k == 16) begin
        n_checks++;
        if (got.cnt !== 5'd31 || got.wt !== 4'd2) begin
          n_fail++; $display("FAIL mode11_wrap got %s expected cnt=31 wt=2", fmt(got));
        end
      end
    end
    n_checks++;
    if (saw_lose || got !== {5'd31, 1'b1, 1'b0, 2'b01, 1'b1, 4'd15, 4'd0}) begin
      n_fail++;
      $display("FAIL mode11_gameover got %s lose_seen=%b expected cnt=31 who=01 wt=15 lt=0",
               fmt(got), saw_lose);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
      void'(sb.pop_front());
    end
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b1, 1'b1, 2'b01, 5'd0);
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e || got.cnt !== 5'd0 || got.lose !== 1'b1 || got.lt !== 4'(k)) begin
        n_fail++; $display("FAIL init_priority %0d got %s expected %s", k, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_hold();
    obs_t got, e;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b0, 2'b00, 5'd31);
    void'(sb.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, (k < 2) ? 2'b00 : 2'b10, 5'd0);
      got = sample(); e = sb.pop_front();
      n_checks++;
      if (got !== e || got.cnt !== 5'd31 || got.win !== 1'b0 || got.wt !== 4'd1) begin
        n_fail++; $display("FAIL hold %0d got %s expected %s", k, fmt(got), fmt(e));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 2'b10, 5'd0);
    got = sample(); e = sb.pop_front();
    n_checks++;
    if (got !== e || got.cnt !== 5'd30) begin
      n_fail++; $display("FAIL hold_resume got %s expected %s", fmt(got), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_gameover_restart();
    test_mode11();
    test_back_to_back();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
